// File: rtl/ring_vc_out_arb.sv
// ring_vc_out_arb
// Output-channel arbiter and even/odd virtual-channel scheduler for one ring
// direction. Two single-flit buffers, one per VC, alternate roles every cycle:
// while polarity = p, buffer p drives the outbound link and buffer ~p accepts
// a round-robin grant from the requesters. A buffer is therefore never filled
// and drained in the same cycle.
//
// Optional feature macro: RING_ARB_HOP_DEC_EN
//   defined   - the 8-bit hop field [HOP_LSB+7:HOP_LSB] of a granted flit is
//               decremented by one (saturating at zero) as it is stored.
//   undefined - flits are stored and forwarded bit-exact.

module ring_vc_out_arb #(
    parameter int NREQ    = 2,
    parameter int DW      = 64,
    parameter int VC_BIT  = 63,
    parameter int HOP_LSB = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 polarity,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 so,
    output logic [DW-1:0]        dout,
    input  logic                 ro
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter sets the buffer/field layout cannot support.
    if (NREQ < 2 || NREQ > 4) begin : gBadNreq
        $error("ring_vc_out_arb: NREQ must be in 2..4");
    end
    if (VC_BIT < 0 || VC_BIT >= DW) begin : gBadVcBit
        $error("ring_vc_out_arb: VC_BIT outside the flit");
    end
    if (HOP_LSB < 0 || HOP_LSB + 8 > DW) begin : gBadHopLsb
        $error("ring_vc_out_arb: hop field outside the flit");
    end

    logic            polarity_q, polarity_d;
    logic [1:0]      full_q, full_d;
    logic [DW-1:0]   bufData_q [2];
    logic [DW-1:0]   bufData_d [2];
    logic [PW-1:0]   ptr_q [2];
    logic [PW-1:0]   ptr_d [2];

    logic [DW-1:0]   reqFlit [NREQ];
    logic [NREQ-1:0] eligible;
    logic            grantValid;
    logic [PW-1:0]   winIdx;
    logic [DW-1:0]   winFlit;
    logic [DW-1:0]   storeFlit;
    logic            extSel;
    logic            intSel;

    // The external buffer follows the phase; the internal one is its opposite.
    assign extSel = polarity_q;
    assign intSel = ~polarity_q;

    assign polarity = polarity_q;
    assign so       = full_q[extSel];
    assign dout     = bufData_q[extSel];

    // Split the flat request bus into one flit per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqFlit[i] = req_data[i*DW +: DW];
        end
    end

    // A requester may compete only for the internal VC, only if that buffer is free, never during reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req[i] && (reqFlit[i][VC_BIT] == intSel) && !full_q[intSel] && !rst;
        end
    end

    // Round-robin search starting at the internal VC's pointer; first eligible requester wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] idxP;
        idx        = 0;
        idxP       = '0;
        grantValid = 1'b0;
        winIdx     = '0;
        gnt        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q[intSel]) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idxP = PW'(idx);
            if (!grantValid && eligible[idxP]) begin
                grantValid = 1'b1;
                winIdx     = idxP;
            end
        end
        if (grantValid) begin
            gnt[winIdx] = 1'b1;
        end
    end

    // Form the flit to be stored, optionally aging its hop count.
    always_comb begin
        winFlit   = reqFlit[winIdx];
        storeFlit = winFlit;
`ifdef RING_ARB_HOP_DEC_EN
        if (winFlit[HOP_LSB +: 8] != 8'h00) begin
            storeFlit[HOP_LSB +: 8] = winFlit[HOP_LSB +: 8] - 8'd1;
        end
`endif
    end

    // Next state: toggle phase, drain the external buffer on a transfer, fill the internal one on a grant.
    always_comb begin
        polarity_d = ~polarity_q;
        full_d     = full_q;
        bufData_d  = bufData_q;
        ptr_d      = ptr_q;
        if (full_q[extSel] && ro) begin
            full_d[extSel] = 1'b0;
        end
        if (grantValid) begin
            full_d[intSel]    = 1'b1;
            bufData_d[intSel] = storeFlit;
            ptr_d[intSel]     = (int'(winIdx) == NREQ - 1) ? '0 : PW'(winIdx + 1'b1);
        end
    end

    // State registers; reset discards any buffered flits and restarts the phase at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            polarity_q   <= 1'b0;
            full_q       <= 2'b00;
            bufData_q[0] <= '0;
            bufData_q[1] <= '0;
            ptr_q[0]     <= '0;
            ptr_q[1]     <= '0;
        end else begin
            polarity_q   <= polarity_d;
            full_q       <= full_d;
            bufData_q[0] <= bufData_d[0];
            bufData_q[1] <= bufData_d[1];
            ptr_q[0]     <= ptr_d[0];
            ptr_q[1]     <= ptr_d[1];
        end
    end

endmodule

// File: tb/tb_ring_vc_out_arb.sv
// tb_ring_vc_out_arb
// Directed bench for ring_vc_out_arb. A per-cycle reference model tracks the
// two VC slots, their round-robin pointers and the phase, and every cycle the
// DUT's polarity/so/dout/gnt are compared with it. Hand-computed literal
// checks at key moments pin the model itself.
// Honours RING_ARB_HOP_DEC_EN for the hop-field expectations.

module tb_ring_vc_out_arb;

    localparam int NREQ = 2;
    localparam int DW   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              ro;
    logic              polarity;
    logic              so;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ*DW-1:0] req_data;
    logic [DW-1:0]     dout;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: state valid for the cycle currently in progress.
    logic        modelPol;
    logic        modelFull [2];
    logic [63:0] modelData [2];
    int          modelPtr  [2];

    localparam logic [63:0] FLIT_AB = 64'h8000_0000_0000_00AB;
    localparam logic [63:0] FLIT_Z  = 64'h8000_0000_0000_00EE;
    localparam logic [63:0] FLIT_A  = 64'h8000_0000_0000_0A0A;
    localparam logic [63:0] FLIT_B  = 64'h8000_0000_0000_0B0B;
    localparam logic [63:0] FLIT_C  = 64'h8000_0000_0000_0C0C;
    localparam logic [63:0] FLIT_X  = 64'h0000_0000_0000_0055;
    localparam logic [63:0] FLIT_D  = 64'h8000_0000_0000_0D0D;
    localparam logic [63:0] FLIT_H5 = 64'h8005_0000_0000_0011;
    localparam logic [63:0] FLIT_H0 = 64'h8000_1234_0000_0022;
    localparam logic [63:0] FLIT_E1 = 64'h8000_0000_0000_0E01;
    localparam logic [63:0] FLIT_E0 = 64'h0000_0000_0000_0E00;
`ifdef RING_ARB_HOP_DEC_EN
    localparam logic [63:0] EXP_H5  = 64'h8004_0000_0000_0011;
`else
    localparam logic [63:0] EXP_H5  = 64'h8005_0000_0000_0011;
`endif

    always #5 clk = ~clk;

    ring_vc_out_arb #(
        .NREQ    (NREQ),
        .DW      (DW),
        .VC_BIT  (63),
        .HOP_LSB (48)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .polarity (polarity),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .so       (so),
        .dout     (dout),
        .ro       (ro)
    );

    // What a stored flit should look like after acceptance.
    function automatic logic [63:0] storedForm(input logic [63:0] f);
        logic [63:0] r;
        r = f;
`ifdef RING_ARB_HOP_DEC_EN
        if (r[55:48] != 8'h00) r[55:48] = r[55:48] - 8'd1;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare DUT with the model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin : compareProc
        int          v;
        int          w;
        int          idx;
        logic [63:0] f;
        logic [NREQ-1:0] expGnt;
        v = modelPol ? 0 : 1;
        w = -1;
        if (!rst && !modelFull[v]) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (modelPtr[v] + k) % NREQ;
                f   = req_data[idx*DW +: DW];
                if (w < 0 && req[idx] && (f[63] == (v == 1))) w = idx;
            end
        end
        expGnt = '0;
        if (w >= 0) expGnt[w] = 1'b1;
        checkOutput("model polarity", 64'(polarity), 64'(modelPol));
        checkOutput("model so",       64'(so),       64'(modelFull[modelPol]));
        checkOutput("model dout",     dout,          modelData[modelPol]);
        checkOutput("model gnt",      64'(gnt),      64'(expGnt));
        if (rst) begin
            modelPol     = 1'b0;
            modelFull[0] = 1'b0;
            modelFull[1] = 1'b0;
            modelData[0] = '0;
            modelData[1] = '0;
            modelPtr[0]  = 0;
            modelPtr[1]  = 0;
        end else begin
            if (modelFull[modelPol] && ro) modelFull[modelPol] = 1'b0;
            if (w >= 0) begin
                modelFull[v] = 1'b1;
                modelData[v] = storedForm(req_data[w*DW +: DW]);
                modelPtr[v]  = (w + 1) % NREQ;
            end
            modelPol = ~modelPol;
        end
    end

    // Move to just after the next active edge, where inputs are changed.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Move to just after the middle of the current cycle, where outputs are read.
    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // Advance until the cycle in progress has the requested phase (bounded).
    task automatic waitPol(input logic p);
        int n;
        n = 0;
        applyStimulus();
        while (modelPol !== p && n < 4) begin
            applyStimulus();
            n++;
        end
        if (modelPol !== p) begin
            missCount++;
            $display("[TB] FAIL waitPol: phase %0b not reached", p);
        end
    endtask

    logic polSeq [4];

    initial begin
        polSeq       = '{1'b1, 1'b0, 1'b1, 1'b0};
        modelPol     = 1'b0;
        modelFull[0] = 1'b0;
        modelFull[1] = 1'b0;
        modelData[0] = '0;
        modelData[1] = '0;
        modelPtr[0]  = 0;
        modelPtr[1]  = 0;
        rst      = 1'b1;
        ro       = 1'b1;
        req      = '0;
        req_data = '0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        probe();
        checkOutput("reset polarity", 64'(polarity), 64'd0);
        checkOutput("reset so",       64'(so),       64'd0);
        checkOutput("reset dout",     dout,          64'd0);
        checkOutput("reset gnt",      64'(gnt),      64'd0);
        applyStimulus();
        rst = 1'b0;
        probe();
        checkOutput("first polarity", 64'(polarity), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            probe();
            checkOutput("polarity seq", 64'(polarity), 64'(polSeq[i]));
        end

        // Single odd flit.
        waitPol(1'b0);
        req = 2'b01;
        req_data[0 +: 64] = FLIT_AB;
        probe();
        checkOutput("single gnt", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b00;
        probe();
        checkOutput("single polarity", 64'(polarity), 64'd1);
        checkOutput("single so",       64'(so),       64'd1);
        checkOutput("single dout",     dout,          FLIT_AB);
        applyStimulus();
        probe();
        checkOutput("single so after", 64'(so), 64'd0);

        // Grant must drop while reset is asserted.
        waitPol(1'b0);
        rst = 1'b1;
        req = 2'b01;
        req_data[0 +: 64] = FLIT_Z;
        probe();
        checkOutput("gnt during rst", 64'(gnt), 64'd0);

        // Round-robin over two odd requesters, pointers fresh from reset.
        applyStimulus();
        rst = 1'b0;
        req = 2'b11;
        req_data[0 +: 64]  = FLIT_A;
        req_data[64 +: 64] = FLIT_B;
        probe();
        checkOutput("rr gnt0", 64'(gnt), 64'h1);
        applyStimulus();
        probe();
        checkOutput("rr dout0", dout, FLIT_A);
        checkOutput("rr idle gnt", 64'(gnt), 64'h0);
        applyStimulus();
        probe();
        checkOutput("rr gnt1", 64'(gnt), 64'h2);
        applyStimulus();
        probe();
        checkOutput("rr dout1", dout, FLIT_B);
        applyStimulus();
        probe();
        checkOutput("rr gnt2", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b10;
        probe();
        checkOutput("rr dout2", dout, FLIT_A);
        applyStimulus();
        probe();
        checkOutput("bp first gnt", 64'(gnt), 64'h2);

        // Backpressure: B stuck in the odd buffer for six cycles.
        applyStimulus();
        ro = 1'b0;
        req_data[64 +: 64] = FLIT_C;
        probe();
        checkOutput("bp so",   64'(so), 64'd1);
        checkOutput("bp dout", dout,    FLIT_B);
        checkOutput("bp gnt",  64'(gnt), 64'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            probe();
            checkOutput("bp hold gnt", 64'(gnt), 64'h0);
            if ((i % 2) == 1) begin
                checkOutput("bp hold so",   64'(so), 64'd1);
                checkOutput("bp hold dout", dout,    FLIT_B);
            end
        end
        applyStimulus();
        ro = 1'b1;
        probe();
        checkOutput("bp release dout", dout, FLIT_B);
        applyStimulus();
        probe();
        checkOutput("bp next gnt", 64'(gnt), 64'h2);
        applyStimulus();
        req = 2'b00;
        probe();
        checkOutput("bp next dout", dout, FLIT_C);

        // VC mismatch, then even drain concurrent with an odd grant.
        applyStimulus();
        req = 2'b01;
        req_data[0 +: 64] = FLIT_X;
        probe();
        checkOutput("vc mismatch gnt", 64'(gnt), 64'h0);
        applyStimulus();
        req = 2'b11;
        req_data[64 +: 64] = FLIT_D;
        probe();
        checkOutput("vc even gnt", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b10;
        probe();
        checkOutput("vc even so",   64'(so),  64'd1);
        checkOutput("vc even dout", dout,     FLIT_X);
        checkOutput("vc odd gnt",   64'(gnt), 64'h2);
        applyStimulus();
        req = 2'b00;
        probe();
        checkOutput("vc odd dout", dout, FLIT_D);

        // Hop field handling.
        applyStimulus();
        req = 2'b01;
        req_data[0 +: 64] = FLIT_H5;
        probe();
        checkOutput("hop5 gnt", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b00;
        probe();
        checkOutput("hop5 dout", dout, EXP_H5);
        applyStimulus();
        req = 2'b01;
        req_data[0 +: 64] = FLIT_H0;
        probe();
        checkOutput("hop0 gnt", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b00;
        probe();
        checkOutput("hop0 dout", dout, FLIT_H0);

        // Fill both buffers, then reset mid-operation.
        applyStimulus();
        req = 2'b11;
        req_data[0 +: 64]  = FLIT_E1;
        req_data[64 +: 64] = FLIT_E0;
        probe();
        checkOutput("fill odd gnt", 64'(gnt), 64'h1);
        applyStimulus();
        req = 2'b10;
        ro  = 1'b0;
        probe();
        checkOutput("fill even gnt", 64'(gnt), 64'h2);
        checkOutput("fill odd dout", dout, FLIT_E1);
        applyStimulus();
        rst = 1'b1;
        req = 2'b00;
        probe();
        checkOutput("pre-rst so",   64'(so), 64'd1);
        checkOutput("pre-rst dout", dout,    FLIT_E0);
        applyStimulus();
        rst = 1'b0;
        ro  = 1'b1;
        probe();
        checkOutput("midrst polarity", 64'(polarity), 64'd0);
        checkOutput("midrst so",       64'(so),       64'd0);
        checkOutput("midrst dout",     dout,          64'd0);
        applyStimulus();
        probe();
        checkOutput("midrst so odd",  64'(so), 64'd0);
        applyStimulus();
        probe();
        checkOutput("midrst so even", 64'(so), 64'd0);

        applyStimulus();
        probe();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
